// File: rtl/fetch_pkg.sv
// fetch_pkg: shared entry type and constants for the instruction-fetch front end
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of fetch entries; flush beats push, pop is moot under flush
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  push_data,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock)
    if (push && !flush && !reset) mem_q[wr_ptr_q] <= push_data;
  assign head = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: PC generator, credit-limited imem requests and prefetch queue feeding ID.
// Define FETCH_STATS_EN to add saturating stall/flush counters.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [XLEN-1:0] out_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     stat_stall_cnt,
  output logic [31:0]     stat_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, pending_pc_q, pending_pc_d;
  logic pending_q, pending_d, pop;
  logic [CW-1:0] count;
  fetch_entry_t head;
  // An in-flight request already owns a slot, so the queue can never overflow
  assign imem_req = !reset && !redirect_valid &&
                    ({1'b0, count} + (CW+1)'(pending_q) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign out_valid = count != '0;
  assign pop = out_valid && out_ready;
  assign out_pc = out_valid ? head.pc : '0;
  assign out_pc_plus4 = out_valid ? head.pc + PC_STEP : '0;
  assign out_instr = out_valid ? head.instr : NOP_INSTR;
  always_comb begin
    fetch_pc_d = redirect_valid ? redirect_pc : imem_req ? fetch_pc_q + PC_STEP : fetch_pc_q;
    pending_d = imem_req;
    pending_pc_d = imem_req ? fetch_pc_q : pending_pc_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pending_q <= 1'b0;
      pending_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q <= pending_d;
      pending_pc_q <= pending_pc_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(pending_q),
    .pop(pop),
    .flush(redirect_valid),
    .push_data('{pc: pending_pc_q, instr: imem_rdata}),
    .head(head),
    .count(count)
  );
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(out_valid && !out_ready && stall_cnt_q != '1);
    flush_cnt_d = flush_cnt_q + 32'(redirect_valid && flush_cnt_q != '1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stat_stall_cnt = stall_cnt_q;
  assign stat_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed stimulus with a PC scoreboard checked on every pop
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;
  logic clock = 0, reset = 1, imem_req, out_valid, out_ready = 0, redirect_valid = 0;
  logic [31:0] imem_addr, imem_rdata = 0, out_pc, out_pc_plus4, out_instr, redirect_pc = 0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_stall_cnt, stat_flush_cnt;
`endif
  int tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] h;

  always #5 clock = ~clock;

  fetch_prefetch_queue dut (
    .clock(clock),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4),
    .out_instr(out_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_stall_cnt(stat_stall_cnt),
    .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  // Synchronous-read memory: instruction word is the inverted address, garbage when idle
  always @(posedge clock) imem_rdata <= imem_req ? ~imem_addr : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  always @(negedge clock) begin : monitor
    logic [31:0] e;
    if (!reset && out_valid && out_ready) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL pop_extra: got pc %h expected no delivery", out_pc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", out_pc, e);
        chk("pop_instr", out_instr, ~e);
        chk("pop_pc4", out_pc_plus4, e + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    out_ready = 1;
    repeat (3) cyc();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_pc4", out_pc_plus4, 0);
    chk("rst_instr", out_instr, NOP_INSTR);
`ifdef FETCH_STATS_EN
    chk("rst_stall_cnt", stat_stall_cnt, 0);
    chk("rst_flush_cnt", stat_flush_cnt, 0);
`endif
    reset = 0;
    load(32'h0);
    #1;
    chk("c0_req", 32'(imem_req), 1);
    chk("c0_addr", imem_addr, 0);
    chk("c0_valid", 32'(out_valid), 0);
    cyc();
    chk("c1_valid", 32'(out_valid), 0);
    chk("c1_addr", imem_addr, 4);
    cyc();
    chk("c2_valid", 32'(out_valid), 1);
    chk("c2_pc", out_pc, 0);
    repeat (10) begin
      cyc();
      chk("stream_valid", 32'(out_valid), 1);
    end
    cyc();
    out_ready = 0;
    h = exp_q[0];
    repeat (10) cyc();
    out_ready = 1;
    #1;
    chk("full_req", 32'(imem_req), 0);
    chk("full_addr", imem_addr, h + 32'd16);
    chk("full_head", out_pc, h);
    cyc();
    chk("resume_req", 32'(imem_req), 1);
    chk("resume_addr", imem_addr, h + 32'd16);
    repeat (8) begin
      cyc();
      chk("resume_valid", 32'(out_valid), 1);
    end
    out_ready = 0;
    repeat (8) cyc();
    reset = 1;
    #1;
    chk("rst2_req_during", 32'(imem_req), 0);
    cyc();
    reset = 0;
    load(32'h0);
    #1;
    chk("rst2_valid", 32'(out_valid), 0);
    chk("rst2_pc", out_pc, 0);
    chk("rst2_pc4", out_pc_plus4, 0);
    chk("rst2_instr", out_instr, NOP_INSTR);
    chk("rst2_req", 32'(imem_req), 1);
    chk("rst2_addr", imem_addr, 0);
    repeat (4) cyc();
    redirect_valid = 1;
    redirect_pc = 32'h100;
    #1;
    chk("rd_req", 32'(imem_req), 0);
    chk("rd_head_valid", 32'(out_valid), 1);
    chk("rd_head_pc", out_pc, 0);
    chk("rd_fetch_pc", imem_addr, 32'd16);
    cyc();
    redirect_valid = 0;
    out_ready = 1;
    load(32'h100);
    #1;
    chk("rd1_valid", 32'(out_valid), 0);
    chk("rd1_req", 32'(imem_req), 1);
    chk("rd1_addr", imem_addr, 32'h100);
    cyc();
    chk("rd2_valid", 32'(out_valid), 0);
    cyc();
    chk("rd3_valid", 32'(out_valid), 1);
    chk("rd3_pc", out_pc, 32'h100);
    repeat (5) cyc();
    redirect_valid = 1;
    redirect_pc = 32'h200;
    h = exp_q[0];
    #1;
    chk("rp_valid", 32'(out_valid), 1);
    chk("rp_head", out_pc, h);
    cyc();
    redirect_valid = 0;
    load(32'h200);
    cyc();
    cyc();
    chk("rp3_valid", 32'(out_valid), 1);
    chk("rp3_pc", out_pc, 32'h200);
    cyc();
    redirect_valid = 1;
    redirect_pc = 32'h300;
    cyc();
    redirect_pc = 32'hFFFF_FFF8;
    #1;
    chk("rr_req", 32'(imem_req), 0);
    cyc();
    redirect_valid = 0;
    load(32'hFFFF_FFF8);
    cyc();
    cyc();
    chk("rr3_pc", out_pc, 32'hFFFF_FFF8);
    chk("rr3_pc4", out_pc_plus4, 32'hFFFF_FFFC);
    repeat (6) cyc();
    chk("wrap_pc", out_pc, 32'h10);
`ifdef FETCH_STATS_EN
    out_ready = 0;
    reset = 1;
    cyc();
    reset = 0;
    load(32'h0);
    #1;
    chk("st_rst_stall", stat_stall_cnt, 0);
    chk("st_rst_flush", stat_flush_cnt, 0);
    repeat (7) cyc();
    out_ready = 1;
    redirect_valid = 1;
    redirect_pc = 32'h40;
    cyc();
    cyc();
    redirect_valid = 0;
    load(32'h40);
    #1;
    chk("st_stall_cnt", stat_stall_cnt, 5);
    chk("st_flush_cnt", stat_flush_cnt, 2);
`endif
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
